// File: rtl/run_seq_pkg.sv
// Shared types and constants for the program-run sequencer and the control decoder.
package run_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_FINISHED
  } run_state_t;

  localparam logic [8:0] DEFAULT_HALT_INSTR = 9'b010000000;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating per-program cycle counter with clear and enable.
// Terminal-count output exists only when RUN_SEQUENCER_WATCHDOG_EN is defined.
module run_cycle_counter #(
  parameter int               CYC_W  = 16,
  parameter logic [CYC_W-1:0] TC_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
`ifdef RUN_SEQUENCER_WATCHDOG_EN
  output logic             tc,
`endif
  output logic [CYC_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CYC_W'(1);
    end
  end

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  // Fires one cycle early so the sequencer leaves RUN exactly as count lands on TC_VAL.
  assign tc = en && (count == (TC_VAL - CYC_W'(1)));
`endif

endmodule

// File: rtl/run_sequencer.sv
// Sequences NUM_PROGS programs through the core: load base PC, run until halt, report.
// Optional watchdog compiled in with RUN_SEQUENCER_WATCHDOG_EN.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int                 NUM_PROGS  = 3,
  parameter int                 PC_W       = 10,
  parameter int                 INSTR_W    = 9,
  parameter logic [INSTR_W-1:0] HALT_INSTR = DEFAULT_HALT_INSTR,
  parameter int                 CYC_W      = 16,
  parameter logic [CYC_W-1:0]   TIMEOUT    = '1,
  localparam int                IDX_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [INSTR_W-1:0]        instr,
  input  logic [NUM_PROGS*PC_W-1:0] prog_base,
  output logic                      pc_load,
  output logic [PC_W-1:0]           pc_load_val,
  output logic                      run_en,
  output logic                      halt,
  output logic [IDX_W-1:0]          prog_idx,
  output logic                      done,
  output logic                      all_done,
  output logic [CYC_W-1:0]          cycle_count,
  output logic                      timeout
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROGS - 1);

  run_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wd_expire;

  assign pc_load     = (state_q == ST_LOAD);
  assign run_en      = (state_q == ST_RUN);
  assign halt        = run_en && (instr == HALT_INSTR);
  assign done        = (state_q == ST_DONE) || (state_q == ST_FINISHED);
  assign all_done    = (state_q == ST_FINISHED);
  assign prog_idx    = idx_q;
  assign pc_load_val = prog_base[int'(idx_q)*PC_W +: PC_W];

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  logic tc;
  logic timeout_q;

  assign wd_expire = tc;
  assign timeout   = timeout_q;

  // Halt takes priority: a coinciding halt never reports a timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else if (state_d == ST_LOAD) begin
      timeout_q <= 1'b0;
    end else if (run_en && !halt && tc) begin
      timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  run_cycle_counter #(
    .CYC_W  (CYC_W),
    .TC_VAL (TIMEOUT)
  ) u_cycle_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (pc_load),
    .en    (run_en),
`ifdef RUN_SEQUENCER_WATCHDOG_EN
    .tc    (tc),
`endif
    .count (cycle_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_ARMED;
      ST_ARMED:    if (!start) state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_RUN;
      ST_RUN:      if (halt || wd_expire) state_d = ST_DONE;
      ST_DONE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_FINISHED;
        end else if (start) begin
          state_d = ST_ARMED;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_FINISHED: state_d = ST_FINISHED;
      default:     state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Parametrised program-run sequencer that sits between the testbench handshake (`start`/`done`) and the single-cycle core datapath. It sequences NUM_PROGS programs back to back, loads each program's base PC, enables the core, detects the halt instruction, and reports completion and per-program cycle counts. It replaces the fixed three-program behavioural loop with a synthesizable FSM.

## Interface
- NUM_PROGS, 3: number of programs run per reset; at least 1.
- PC_W, 10: program counter width.
- INSTR_W, 9: instruction width.
- HALT_INSTR, 9'b010000000: instruction encoding that ends a program.
- CYC_W, 16: cycle-counter width.
- TIMEOUT, 16'hFFFF: watchdog limit in cycles, used only with the watchdog configured in.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run request from the testbench; level-sensitive.
- instr  in  INSTR_W  instruction currently fetched by the core.
- prog_base  in  NUM_PROGS*PC_W  base PC of each program; program k occupies slice [k*PC_W +: PC_W].
- pc_load  out  1  one-cycle strobe that forces the core PC to pc_load_val.
- pc_load_val  out  PC_W  base PC of the current program.
- run_en  out  1  core enable; the core updates PC, registers and memory only while high.
- halt  out  1  combinational: run_en & (instr == HALT_INSTR).
- prog_idx  out  $clog2(NUM_PROGS) (min 1)  index of the current or last program.
- done  out  1  current program finished; held until the next start.
- all_done  out  1  every program has finished.
- cycle_count  out  CYC_W  cycles spent in RUN for the current program.
- timeout  out  1  program ended by the watchdog (constant 0 when the watchdog is compiled out).

## Operation
- States: IDLE, ARMED, LOAD, RUN, DONE, FINISHED.
- IDLE: moves to ARMED when start = 1.
- ARMED: moves to LOAD when start = 0. Programs begin on the falling edge of start.
- LOAD (exactly 1 cycle):
  - pc_load = 1 and pc_load_val = prog_base[prog_idx].
  - cycle_count is cleared.
  - Next state is RUN.
- RUN:
  - run_en = 1.
  - cycle_count increments each cycle and saturates at all-ones.
  - When halt = 1 at a clock edge, the FSM moves to DONE. The halt instruction itself produces no architectural effect; the core gates its writes with halt.
- DONE:
  - done = 1, run_en = 0.
  - cycle_count and prog_idx are held.
  - If prog_idx == NUM_PROGS-1, the next state is FINISHED.
  - Otherwise, start = 1 increments prog_idx, clears done and moves to ARMED.
- FINISHED:
  - done = 1 and all_done = 1.
  - start is ignored; only reset leaves this state.
- start is ignored in LOAD and RUN; a program cannot be aborted except by reset.
- pc_load_val is a pure mux on prog_idx and is valid in every state.

## Timing
- Reset values: state IDLE, prog_idx 0, done 0, all_done 0, run_en 0, pc_load 0, cycle_count 0, timeout 0.
- Reset asserted mid-run drops everything to the reset values immediately, without waiting for a clock edge.
- Latency from start falling to pc_load is 1 cycle (ARMED→LOAD). The first RUN cycle follows 1 cycle later.
- Halt seen at edge N: done = 1 and run_en = 0 from edge N onward. cycle_count includes the halt cycle.
- A program whose first instruction is HALT_INSTR gives cycle_count = 1.
- Re-arm: start rising while in DONE clears done on that edge. The next pc_load occurs 1 cycle after start falls.

## Configuration
- RUN_SEQUENCER_WATCHDOG_EN defined:
  - In RUN, if cycle_count reaches TIMEOUT before a halt, the FSM moves to DONE with timeout = 1.
  - timeout is held until the next LOAD and cleared on entering LOAD.
  - If halt and the timeout condition coincide on the same edge, halt wins and timeout stays 0.
- RUN_SEQUENCER_WATCHDOG_EN undefined: no watchdog compare logic is built, timeout is tied to 0, and the sequencer runs until halt.

## Structure
- Package `run_seq_pkg` holds:
  - the state enum `run_state_t`;
  - the default `HALT_INSTR` constant, shared with the control decoder.
- Sub-module `run_cycle_counter` contains:
  - the saturating CYC_W counter with clear and enable;
  - a terminal-count output used by the watchdog.

## Test plan
- Reset release, then start 1→0 with prog_base[0] = 0: pc_load pulses with pc_load_val = 0 one cycle after start falls, and run_en rises on the following cycle.
- HALT_INSTR presented on RUN cycle 5: done = 1, run_en = 0, cycle_count = 5, prog_idx = 0, and done holds until start rises.
- Three programs with prog_base = {200, 100, 0}, each halting after 4 cycles: pc_load_val is 0, 100, 200 in turn, and all_done = 1 after the third halt. A fourth start pulse leaves state, done and prog_idx = 2 unchanged.
- start toggled during RUN: no effect on run_en, pc_load or prog_idx.
- Reset asserted on the 3rd RUN cycle of program 1: all outputs return to their reset values immediately, and the next start sequence runs program 0.
- Watchdog (with RUN_SEQUENCER_WATCHDOG_EN, TIMEOUT = 8) and no halt: DONE is reached with timeout = 1 and cycle_count = 8. With halt on cycle 8, timeout = 0.
